// File: rtl/led_sotp_gen_if.sv
// Pixel FIFO read port as seen by the LED driver (master pops, slave is the FIFO).
interface led_sotp_gen_if;
  logic        in_rd_fifo_empty;
  logic [31:0] in_rd_fifo_data;
  logic        out_rd_fifo_en;

  modport master (input in_rd_fifo_empty, in_rd_fifo_data, output out_rd_fifo_en);
  modport slave  (output in_rd_fifo_empty, in_rd_fifo_data, input out_rd_fifo_en);
endinterface

// File: rtl/led_sotp_gen.sv
// Serial NRZ LED driver: pops pixel words, optional white extraction, shifts
// NUM_CH*8 bits MSB-first with fixed high/low phase lengths, emits stream-reset latches.
module led_sotp_gen #(
  parameter int T0H       = 16,
  parameter int T0L       = 74,
  parameter int T1H       = 45,
  parameter int T1L       = 45,
  parameter int STR_RST   = 7681,
  parameter int NUM_CH    = 4,
  parameter int W_EXTRACT = 1,
  parameter int ORDER     = 0,
  parameter int AUTO_RST  = 0
) (
  input  logic                clk,
  input  logic                rst,
  led_sotp_gen_if.master      fifo,
  output logic                out_sig,
  output logic                out_busy,
  output logic [15:0]         out_pix_count
);
  localparam int NB  = NUM_CH * 8;
  localparam int BW  = $clog2(NB);
  localparam int TMA = (T0H > T0L) ? T0H : T0L;
  localparam int TMB = (T1H > T1L) ? T1H : T1L;
  localparam int TMC = (TMA > TMB) ? TMA : TMB;
  localparam int TMX = (TMC > STR_RST) ? TMC : STR_RST;
  localparam int TW  = $clog2(TMX + 1);
  localparam int AW  = (AUTO_RST > 0) ? $clog2(AUTO_RST + 1) : 1;
  localparam bit XW  = (NUM_CH == 4) && (W_EXTRACT == 1);

  localparam logic [TW-1:0] T0H_M = TW'(T0H - 1);
  localparam logic [TW-1:0] T0L_M = TW'(T0L - 1);
  localparam logic [TW-1:0] T1H_M = TW'(T1H - 1);
  localparam logic [TW-1:0] T1L_M = TW'(T1L - 1);
  localparam logic [TW-1:0] STR_M = TW'(STR_RST - 1);
  localparam logic [AW-1:0] AUTO_M = AW'(AUTO_RST);

  typedef enum logic [2:0] {IDLE, WAIT_DAT, LOAD, CONV1, CONV2, SHIFT, LATCH} state_t;
  state_t state, nxt;

  logic [7:0]    r, g, b, m;
  logic [NB-1:0] sreg;
  logic [BW-1:0] bit_cnt;
  logic [TW-1:0] tcnt;
  logic [AW-1:0] idle_cnt;
  logic          hi_ph, sent;

  logic        hi_end, lo_end, last_bit, auto_hit;
  logic [7:0]  mn_rg, mn, r2, g2, b2, w2;
  logic [31:0] full;
  logic        unused_bits;

  assign hi_end   = hi_ph && (tcnt == (sreg[NB-1] ? T1H_M : T0H_M));
  assign lo_end   = !hi_ph && (tcnt == (sreg[NB-1] ? T1L_M : T0L_M));
  assign last_bit = (bit_cnt == BW'(NB - 1));
  assign auto_hit = (AUTO_RST > 0) && sent && (idle_cnt == AUTO_M);
  assign out_sig  = (state == SHIFT) && hi_ph;

  assign mn_rg = (r < g) ? r : g;
  assign mn    = (mn_rg < b) ? mn_rg : b;
  // m is the min of all three, so these subtractions cannot underflow
  assign r2    = XW ? r - m : r;
  assign g2    = XW ? g - m : g;
  assign b2    = XW ? b - m : b;
  assign w2    = XW ? m : 8'd0;
  assign full  = {(ORDER == 1) ? g2 : r2, (ORDER == 1) ? r2 : g2, b2, w2};
  assign unused_bits = ^{fifo.in_rd_fifo_data[29:24], full[7:0]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt                 = state;
    fifo.out_rd_fifo_en = 1'b0;
    out_busy            = 1'b1;
    case (state)
      IDLE: begin
        out_busy = 1'b0;
        if (!fifo.in_rd_fifo_empty) begin
          fifo.out_rd_fifo_en = 1'b1;
          nxt = WAIT_DAT;
        end else if (auto_hit) begin
          nxt = LATCH;
        end
      end
      WAIT_DAT: nxt = LOAD;
      LOAD: begin
        if (!fifo.in_rd_fifo_data[31])     nxt = IDLE;
        else if (fifo.in_rd_fifo_data[30]) nxt = LATCH;
        else                               nxt = CONV1;
      end
      CONV1: nxt = CONV2;
      CONV2: nxt = SHIFT;
      SHIFT: if (lo_end && last_bit) nxt = IDLE;
      LATCH: if (tcnt == STR_M) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r <= '0; g <= '0; b <= '0; m <= '0;
      sreg <= '0; bit_cnt <= '0; tcnt <= '0; idle_cnt <= '0;
      hi_ph <= 1'b0; sent <= 1'b0; out_pix_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (!fifo.in_rd_fifo_empty)          idle_cnt <= '0;
          else if (sent && idle_cnt != AUTO_M) idle_cnt <= idle_cnt + 1'b1;
        end
        LOAD: begin
          r    <= fifo.in_rd_fifo_data[15:8];
          g    <= fifo.in_rd_fifo_data[23:16];
          b    <= fifo.in_rd_fifo_data[7:0];
          tcnt <= '0;
        end
        CONV1: m <= mn;
        CONV2: begin
          sreg    <= full[31 -: NB];
          bit_cnt <= '0;
          tcnt    <= '0;
          hi_ph   <= 1'b1;
        end
        SHIFT: begin
          if (hi_ph) begin
            if (hi_end) begin hi_ph <= 1'b0; tcnt <= '0; end
            else tcnt <= tcnt + 1'b1;
          end else if (lo_end) begin
            tcnt    <= '0;
            hi_ph   <= 1'b1;
            sreg    <= sreg << 1;
            bit_cnt <= bit_cnt + 1'b1;
            if (last_bit) begin
              sent <= 1'b1;
              if (out_pix_count != 16'hFFFF) out_pix_count <= out_pix_count + 16'd1;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        LATCH: begin
          if (tcnt == STR_M) begin
            tcnt <= '0; out_pix_count <= '0; sent <= 1'b0; idle_cnt <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_led_sotp_gen.sv
// Three driver configurations; a per-instance monitor decodes each busy burst
// on the LED line and checks it against a queue of expected events.
module tb_led_sotp_gen;
  localparam int T0H = 2, T0L = 4, T1H = 4, T1L = 2, STR = 20;
  localparam int K_PIX = 0, K_LAT = 1, K_DIS = 2;

  typedef struct {
    int          kind;
    logic [31:0] bits;
    int          len;    // bit count for pixels, busy-run length otherwise
    int          cnt;
    int          gap_lo;
    int          gap_hi; // 0 = gap not checked
  } exp_t;

  logic       clk = 1'b0;
  logic [2:0] rst = 3'b111;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input int inst, input longint act, input longint expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s inst %0d: got 0x%0h, expected 0x%0h", name, inst, act, expv);
    end
  endtask

  task automatic check_range(input string name, input int inst, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s inst %0d: got %0d, expected %0d..%0d", name, inst, act, lo, hi);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g
    localparam int NCH = (gi == 1) ? 3 : 4;
    localparam int ORD = (gi == 1) ? 1 : 0;
    localparam int AR  = (gi == 2) ? 30 : 0;

    led_sotp_gen_if ifc();
    logic        sig, busy;
    logic [15:0] pcnt;

    led_sotp_gen #(.T0H(T0H), .T0L(T0L), .T1H(T1H), .T1L(T1L), .STR_RST(STR),
                   .NUM_CH(NCH), .W_EXTRACT(1), .ORDER(ORD), .AUTO_RST(AR)) dut (
      .clk(clk), .rst(rst[gi]), .fifo(ifc.master),
      .out_sig(sig), .out_busy(busy), .out_pix_count(pcnt));

    // FIFO model: registered read data, one clock after the pop request
    logic [31:0] fq[$];
    exp_t        exq[$];
    int pushed = 0, popped = 0, bad_pop = 0, unexp = 0;
    assign ifc.in_rd_fifo_empty = (pushed == popped);

    always @(posedge clk) begin
      if (ifc.out_rd_fifo_en) begin
        if (busy || fq.size() == 0) bad_pop++;
        if (fq.size() != 0) begin
          ifc.in_rd_fifo_data <= fq.pop_front();
          popped <= popped + 1;
        end
      end
    end

    int in_run = 0, run_len = 0, pre = 0, nb = 0, hi = 0, lo = 0, seen_hi = 0, tbad = 0;
    int gap = 0, gap_at = 0;
    logic [31:0] bits = '0;
    exp_t e;

    task automatic close_bit();
      if (!((hi == T0H && lo == T0L) || (hi == T1H && lo == T1L))) tbad++;
      bits = {bits[30:0], (hi == T1H)};
      nb++; hi = 0; lo = 0;
    endtask

    task automatic finish_run();
      if (exq.size() == 0) begin
        unexp++; n_fail++;
        $display("FAIL unexpected_run inst %0d: got busy run of %0d clocks, expected none", gi, run_len);
      end else begin
        e = exq.pop_front();
        if (e.gap_hi > 0) check_range("idle_gap", gi, gap_at, e.gap_lo, e.gap_hi);
        if (e.kind == K_PIX) begin
          check("pixel_bits", gi, bits, e.bits);
          check("bit_count", gi, nb, e.len);
          check("bit_timing_errs", gi, tbad, 0);
          check("pre_shift_clks", gi, pre, 4);
          check("pixel_run_len", gi, run_len, 4 + (T0H + T0L) * e.len);
        end else begin
          check("high_pulses", gi, seen_hi, 0);
          check(e.kind == K_LAT ? "latch_run_len" : "discard_run_len", gi, run_len, e.len);
        end
        check("pix_count", gi, pcnt, e.cnt);
      end
    endtask

    always @(negedge clk) begin
      if (rst[gi]) begin
        if (in_run != 0 && exq.size() > 0) void'(exq.pop_front());
        in_run = 0; gap = 0;
      end else if (busy) begin
        if (in_run == 0) begin
          in_run = 1; run_len = 0; pre = 0; nb = 0; hi = 0; lo = 0;
          seen_hi = 0; tbad = 0; bits = '0; gap_at = gap;
        end
        run_len++;
        if (sig) begin
          if (lo > 0) close_bit();
          hi++; seen_hi = 1;
        end else if (seen_hi != 0) lo++;
        else pre++;
      end else if (in_run != 0) begin
        if (seen_hi != 0) close_bit();
        finish_run();
        in_run = 0; gap = 1;
      end else begin
        gap++;
      end
    end
  end

  task automatic push_word(input int inst, input logic [31:0] w);
    case (inst)
      0: begin g[0].fq.push_back(w); g[0].pushed++; end
      1: begin g[1].fq.push_back(w); g[1].pushed++; end
      default: begin g[2].fq.push_back(w); g[2].pushed++; end
    endcase
  endtask

  task automatic expect_ev(input int inst, input int kind, input logic [31:0] bits, input int len,
                           input int cnt, input int glo, input int ghi);
    exp_t x;
    x.kind = kind; x.bits = bits; x.len = len; x.cnt = cnt; x.gap_lo = glo; x.gap_hi = ghi;
    case (inst)
      0: g[0].exq.push_back(x);
      1: g[1].exq.push_back(x);
      default: g[2].exq.push_back(x);
    endcase
  endtask

  function automatic bit settled(input int inst);
    case (inst)
      0: return g[0].exq.size() == 0 && g[0].pushed == g[0].popped && !g[0].busy;
      1: return g[1].exq.size() == 0 && g[1].pushed == g[1].popped && !g[1].busy;
      default: return g[2].exq.size() == 0 && g[2].pushed == g[2].popped && !g[2].busy;
    endcase
  endfunction

  task automatic drain(input int inst, input int maxc);
    int c = 0;
    bit done = 0;
    while (!done && c < maxc) begin
      @(negedge clk); #1;
      done = settled(inst);
      c++;
    end
    check("drain_timeout", inst, done, 1);
  endtask

  initial begin
    int c;
    repeat (3) @(negedge clk);
    #1;
    check("reset_state", 0, {g[0].sig, g[0].busy, g[0].ifc.out_rd_fifo_en, g[0].pcnt}, 0);
    check("reset_state", 1, {g[1].sig, g[1].busy, g[1].ifc.out_rd_fifo_en, g[1].pcnt}, 0);
    check("reset_state", 2, {g[2].sig, g[2].busy, g[2].ifc.out_rd_fifo_en, g[2].pcnt}, 0);
    rst = 3'b000;

    // RGBW with white extraction: G=40 R=50 B=30 -> R20 G10 B00 W30
    expect_ev(0, K_PIX, 32'h20100030, 32, 1, 0, 0);
    push_word(0, 32'h80405030);
    drain(0, 400);

    // RGB, G-first order, no white
    expect_ev(1, K_PIX, 32'h00405030, 24, 1, 0, 0);
    push_word(1, 32'h80405030);
    drain(1, 400);

    // stream-reset word (WAIT+LOAD+20 latch clocks), then an invalid word
    expect_ev(0, K_LAT, '0, 2 + STR, 0, 0, 0);
    expect_ev(0, K_DIS, '0, 2, 0, 0, 0);
    push_word(0, 32'hC0000000);
    push_word(0, 32'h00FFFFFF);
    drain(0, 200);

    // auto latch after 30 idle clocks, and only once
    expect_ev(2, K_PIX, 32'h20100030, 32, 1, 0, 0);
    expect_ev(2, K_LAT, '0, STR, 0, 30, 31);
    push_word(2, 32'h80405030);
    drain(2, 500);
    repeat (100) @(negedge clk);

    // three back-to-back pixels
    expect_ev(0, K_PIX, 32'h00FF0000, 32, 1, 0, 0);
    expect_ev(0, K_PIX, 32'h11002211, 32, 2, 1, 19);
    expect_ev(0, K_PIX, 32'h000000FF, 32, 3, 1, 19);
    push_word(0, 32'h80FF0000);
    push_word(0, 32'h80112233);
    push_word(0, 32'h80FFFFFF);
    drain(0, 1000);

    // reset during bit 5, then a clean pixel
    expect_ev(0, K_PIX, 32'h20100030, 32, 4, 0, 0);
    push_word(0, 32'h80405030);
    c = 0;
    while (!g[0].busy && c < 20) begin @(negedge clk); c++; end
    check("busy_seen", 0, g[0].busy, 1);
    repeat (35) @(posedge clk);
    #1 rst[0] = 1'b1;
    @(posedge clk);
    #1;
    check("rst_sig", 0, g[0].sig, 0);
    check("rst_busy", 0, g[0].busy, 0);
    check("rst_pix_count", 0, g[0].pcnt, 0);
    check("rst_fifo_en", 0, g[0].ifc.out_rd_fifo_en, 0);
    @(negedge clk);
    #1 rst[0] = 1'b0;
    expect_ev(0, K_PIX, 32'h00502050, 32, 1, 0, 0);
    push_word(0, 32'h80A05070);
    drain(0, 400);
    repeat (10) @(negedge clk);

    check("pop_count", 0, g[0].popped, 8);
    check("pop_count", 1, g[1].popped, 1);
    check("pop_count", 2, g[2].popped, 1);
    check("bad_pops", 0, g[0].bad_pop, 0);
    check("bad_pops", 1, g[1].bad_pop, 0);
    check("bad_pops", 2, g[2].bad_pop, 0);
    check("unexpected_runs", 2, g[2].unexp, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end
endmodule
